// File: rtl/quarter_square_table_writer.sv
// rtl/quarter_square_table_writer.sv - streams the quarter-square sum/difference tables to a sink
module quarter_square_table_writer #(
  parameter bit AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [8:0]  wr_addr,
  output logic [15:0] sum_data,
  output logic [15:0] diff_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t      state_q;
  logic        auto_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic [8:0]  addr_q;
  logic [15:0] sum_q;
  logic [15:0] diff_q;

  logic [9:0]  half_n;
  logic [9:0]  half_m;
  logic [15:0] sum_d;
  logic [15:0] diff_d;

  // (n+1)>>1 for the sum step, and m>>1 with m = 512-n for the mirrored difference step
  assign half_n = ({1'b0, addr_q} + 10'd1) >> 1;
  assign half_m = (10'd512 - {1'b0, addr_q}) >> 1;

  // Next table words for address addr_q+1, built from the current words with add/subtract only
  always_comb begin
    sum_d  = sum_q + {6'b0, half_n};
    diff_d = diff_q;
    if (addr_q < 9'd255) begin
      diff_d = sum_d;
    end else if (addr_q == 9'd255) begin
      diff_d = 16'd16384;
    end else begin
      diff_d = diff_q - {6'b0, half_m};
    end
  end

  // Fill sequencer: IDLE/DONE wait for a start, FILL walks addresses 0..511 under handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      auto_q  <= AUTO_START;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 9'd0;
      sum_q   <= 16'd0;
      diff_q  <= 16'd0;
    end else begin
      // The automatic start is offered only on the first clock after reset release
      auto_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start || (state_q == ST_IDLE && auto_q)) begin
            state_q <= ST_FILL;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            addr_q  <= 9'd0;
            sum_q   <= 16'd0;
            diff_q  <= 16'd0;
          end
        end
        ST_FILL: begin
          if (wr_ready) begin
            if (addr_q == 9'd511) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_q + 9'd1;
              sum_q  <= sum_d;
              diff_q <= diff_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_valid  = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_addr   = addr_q;
  assign sum_data  = sum_q;
  assign diff_data = diff_q;

endmodule

// File: tb/tb_quarter_square_table_writer.sv
// tb/tb_quarter_square_table_writer.sv - scoreboard bench for quarter_square_table_writer
module tb_quarter_square_table_writer;

  typedef struct packed {
    logic [8:0]  addr;
    logic [15:0] sum;
    logic [15:0] diff;
  } word_t;

  logic        clk = 1'b0;
  // auto-start instance
  logic        a_rst = 1'b1, a_start = 1'b0, a_ready = 1'b1;
  logic        a_valid, a_busy, a_done;
  logic [8:0]  a_addr;
  logic [15:0] a_sum, a_diff;
  // manual-start instance
  logic        m_rst = 1'b1, m_start = 1'b0, m_ready = 1'b1;
  logic        m_valid, m_busy, m_done;
  logic [8:0]  m_addr;
  logic [15:0] m_sum, m_diff;

  int checks = 0;
  int errors = 0;
  bit a_rand = 1'b0;

  word_t sb_a[$];
  word_t sb_m[$];
  bit    pstall[2];
  word_t pword[2];
  bit    exp_done[2];
  int    got_sum[512];
  int    got_diff[512];

  quarter_square_table_writer #(.AUTO_START(1'b1)) u_auto (
    .clk(clk), .reset(a_rst), .start(a_start), .wr_valid(a_valid), .wr_ready(a_ready),
    .wr_addr(a_addr), .sum_data(a_sum), .diff_data(a_diff), .busy(a_busy), .done(a_done)
  );

  quarter_square_table_writer #(.AUTO_START(1'b0)) u_man (
    .clk(clk), .reset(m_rst), .start(m_start), .wr_valid(m_valid), .wr_ready(m_ready),
    .wr_addr(m_addr), .sum_data(m_sum), .diff_data(m_diff), .busy(m_busy), .done(m_done)
  );

  always #5 clk = ~clk;

  // Reference model: quarter squares from plain arithmetic
  function automatic int qf(input int n);
    return (n * n) / 4;
  endfunction

  function automatic word_t model_word(input int n);
    word_t w;
    w.addr = n[8:0];
    w.sum  = 16'(qf(n));
    w.diff = (n < 256) ? 16'(qf(n)) : 16'(qf(512 - n));
    return w;
  endfunction

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_fill(input int id);
    for (int n = 0; n < 512; n++) begin
      if (id == 0) sb_a.push_back(model_word(n));
      else         sb_m.push_back(model_word(n));
    end
  endtask

  // Monitor: compares each presented word against the scoreboard head, pops on acceptance
  task automatic mon(input int id, input logic v, input logic r, input logic b, input logic d, input word_t w);
    word_t e;
    bit    have;
    check($sformatf("busy_eq_valid[%0d]", id), b === v, b, v);
    if (exp_done[id]) begin
      check($sformatf("done_after_511[%0d]", id), d === 1'b1 && v === 1'b0, {d, v}, 2);
      exp_done[id] = 1'b0;
    end
    if (v === 1'b1) begin
      if (pstall[id])
        check($sformatf("stall_hold[%0d]", id), w === pword[id], w, pword[id]);
      have = (id == 0) ? (sb_a.size() > 0) : (sb_m.size() > 0);
      check($sformatf("word_expected[%0d]", id), have, 1, 0);
      if (have) begin
        e = (id == 0) ? sb_a[0] : sb_m[0];
        checks++;
        if (w !== e) begin
          errors++;
          $display("FAIL word[%0d] actual addr=%0d sum=%0d diff=%0d required addr=%0d sum=%0d diff=%0d",
                   id, w.addr, w.sum, w.diff, e.addr, e.sum, e.diff);
        end
        if (r === 1'b1) begin
          if (id == 0) begin
            void'(sb_a.pop_front());
            got_sum[e.addr]  = int'(w.sum);
            got_diff[e.addr] = int'(w.diff);
          end else begin
            void'(sb_m.pop_front());
          end
          if (e.addr == 9'd511) exp_done[id] = 1'b1;
        end
      end
    end
    pstall[id] = (v === 1'b1) && (r !== 1'b1);
    pword[id]  = w;
  endtask

  always @(negedge clk) begin
    mon(0, a_valid, a_ready, a_busy, a_done, {a_addr, a_sum, a_diff});
    mon(1, m_valid, m_ready, m_busy, m_done, {m_addr, m_sum, m_diff});
  end

  // Ready drivers: auto instance constant or random, manual instance always random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      a_ready = a_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic pulse_start(input int id);
    @(posedge clk); #1;
    if (id == 0) a_start = 1'b1; else m_start = 1'b1;
    @(posedge clk); #1;
    if (id == 0) a_start = 1'b0; else m_start = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (n < budget && !hit) begin
      @(negedge clk); #2;
      hit = (id == 0) ? (a_done === 1'b1) : (m_done === 1'b1);
      n++;
    end
    check($sformatf("wait_done[%0d]", id), hit, n, budget);
  endtask

  task automatic wait_addr(input int id, input int addr, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (n < budget && !hit) begin
      @(negedge clk); #2;
      hit = (id == 0) ? (a_valid === 1'b1 && a_addr == 9'(addr))
                      : (m_valid === 1'b1 && m_addr == 9'(addr));
      n++;
    end
    check($sformatf("wait_addr%0d[%0d]", addr, id), hit, n, budget);
  endtask

  initial begin
    int spot_a[6] = '{3, 255, 256, 257, 510, 511};
    int spot_s[6] = '{2, 16256, 16384, 16512, 65025, 65280};
    int spot_d[6] = '{2, 16256, 16384, 16256, 1, 0};
    int first_cyc;
    int cyc;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs_auto", {a_valid, a_busy, a_done, a_addr, a_sum, a_diff} == '0,
          {a_valid, a_busy, a_done, a_addr}, 0);
    check("reset_outputs_man", {m_valid, m_busy, m_done, m_addr, m_sum, m_diff} == '0,
          {m_valid, m_busy, m_done, m_addr}, 0);

    // Auto-start fill with wr_ready held high
    push_fill(0);
    @(posedge clk); #1;
    a_rst = 1'b0;
    m_rst = 1'b0;
    @(posedge clk); #1;
    check("auto_first_valid", a_valid === 1'b1 && a_addr == 9'd0 && a_sum == 16'd0 && a_diff == 16'd0,
          a_valid, 1);
    @(negedge clk); #2;
    first_cyc = 0;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 2000 && !seen) begin
      @(negedge clk); #2;
      cyc++;
      seen = (a_done === 1'b1);
    end
    check("fill_time_512", seen && cyc == 512, cyc - first_cyc, 512);
    check("sb_auto_drained", sb_a.size() == 0, sb_a.size(), 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("spot_sum_%0d", spot_a[i]), got_sum[spot_a[i]] == spot_s[i], got_sum[spot_a[i]], spot_s[i]);
      check($sformatf("spot_diff_%0d", spot_a[i]), got_diff[spot_a[i]] == spot_d[i], got_diff[spot_a[i]], spot_d[i]);
    end
    // Auto-start happens only once; the manual instance never left IDLE
    repeat (20) @(posedge clk);
    #2;
    check("auto_stays_done", a_done === 1'b1 && a_valid === 1'b0, {a_done, a_valid}, 2);
    check("man_idle", m_valid === 1'b0 && m_done === 1'b0 && m_busy === 1'b0, {m_valid, m_done, m_busy}, 0);

    // Random stalls, reset pulse at address 100, automatic restart after release
    a_rand = 1'b1;
    push_fill(0);
    pulse_start(0);
    check("restart_from_done", a_valid === 1'b1 && a_done === 1'b0 && a_addr == 9'd0, {a_valid, a_done}, 2);
    wait_addr(0, 100, 2000);
    #1;
    a_rst = 1'b1;
    #1;
    check("async_reset_clear", {a_valid, a_busy, a_done, a_addr, a_sum, a_diff} == '0,
          {a_valid, a_busy, a_done, a_addr}, 0);
    sb_a.delete();
    exp_done[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_hold", {a_valid, a_busy, a_done, a_addr, a_sum, a_diff} == '0, a_valid, 0);
    push_fill(0);
    @(posedge clk); #1;
    a_rst = 1'b0;
    @(posedge clk); #1;
    check("restart_after_reset", a_valid === 1'b1 && a_addr == 9'd0, {a_valid, a_addr}, 512);
    wait_done(0, 4000);
    check("sb_auto_stall_drained", sb_a.size() == 0, sb_a.size(), 0);

    // Manual instance: start, ignored start mid-fill, restart from DONE
    push_fill(1);
    pulse_start(1);
    check("man_start_valid", m_valid === 1'b1 && m_addr == 9'd0 && m_sum == 16'd0, {m_valid, m_addr}, 512);
    wait_addr(1, 40, 2000);
    pulse_start(1);
    wait_done(1, 4000);
    check("sb_man_drained", sb_m.size() == 0, sb_m.size(), 0);
    push_fill(1);
    pulse_start(1);
    check("man_done_clears", m_done === 1'b0 && m_valid === 1'b1 && m_addr == 9'd0, {m_done, m_valid}, 1);
    wait_done(1, 4000);
    check("sb_man_repeat_drained", sb_m.size() == 0, sb_m.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
